// File: rtl/nat_conn_arbiter.sv
// nat_conn_arbiter: round-robin sharing of one connection-table lookup port among NUM_CH channels
module nat_conn_arbiter #(
   parameter int NUM_CH  = 2,
   parameter int TUPLE_W = 128,
   parameter int CONN_W  = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH*TUPLE_W-1:0]  ch_tuple_data,
   input  logic [NUM_CH-1:0]          ch_tuple_valid,
   output logic [NUM_CH-1:0]          ch_tuple_ready,
   output logic [NUM_CH*CONN_W-1:0]   ch_conn_data,
   output logic [NUM_CH-1:0]          ch_conn_valid,
   output logic [NUM_CH-1:0]          ch_conn_err,
   output logic [TUPLE_W-1:0]         tbl_tuple_data,
   output logic                       tbl_tuple_valid,
   input  logic [CONN_W-1:0]          tbl_conn_data,
   input  logic                       tbl_conn_valid,
   output logic [31:0]                req_cnt,
   output logic [31:0]                timeout_cnt
);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [NUM_CH-1:0] ONE = 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state;
   logic [CW-1:0] ptr, gnt, pick, idx;
   logic [TW-1:0] timer;
   logic any;
   // pick the first requesting channel after the last grant, wrapping around
   always_comb begin
      any  = 1'b0;
      pick = ptr;
      idx  = ptr;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = CW'((int'(ptr) + k) % NUM_CH);
         if (!any && ch_tuple_valid[idx]) begin
            any  = 1'b1;
            pick = idx;
         end
      end
   end
   // accept pulse only in IDLE; forced low while reset is held so every output reads 0
   always_comb ch_tuple_ready = (state == IDLE && any && reset) ? ONE << pick : '0;
   // lookup sequencer: grant, issue one table request, then wait for response or timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         ptr             <= CW'(NUM_CH - 1);
         gnt             <= '0;
         timer           <= '0;
         tbl_tuple_data  <= '0;
         tbl_tuple_valid <= 1'b0;
         ch_conn_data    <= '0;
         ch_conn_valid   <= '0;
         ch_conn_err     <= '0;
         req_cnt         <= '0;
         timeout_cnt     <= '0;
      end else begin
         tbl_tuple_valid <= 1'b0;
         ch_conn_valid   <= '0;
         ch_conn_err     <= '0;
         case (state)
            IDLE: if (any) begin
               gnt             <= pick;
               ptr             <= pick;
               tbl_tuple_data  <= ch_tuple_data[pick*TUPLE_W +: TUPLE_W];
               tbl_tuple_valid <= 1'b1;
               req_cnt         <= req_cnt + {31'b0, req_cnt != '1};
               state           <= ISSUE;
            end
            ISSUE: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: if (tbl_conn_valid) begin
               ch_conn_data[gnt*CONN_W +: CONN_W] <= tbl_conn_data;
               ch_conn_valid <= ONE << gnt;
               state         <= IDLE;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               ch_conn_data[gnt*CONN_W +: CONN_W] <= '0;
               ch_conn_valid <= ONE << gnt;
               ch_conn_err   <= ONE << gnt;
               timeout_cnt   <= timeout_cnt + {31'b0, timeout_cnt != '1};
               state         <= IDLE;
            end else begin
               timer <= timer + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nat_conn_arbiter.sv
// tb_nat_conn_arbiter: randomized check of nat_conn_arbiter against a transaction-level model
module tb_nat_conn_arbiter;
   localparam int N  = 4;
   localparam int TW = 128;
   localparam int CW = 16;
   localparam int TO = 8;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [N*TW-1:0] ch_tuple_data = '0;
   logic [N-1:0] ch_tuple_valid = '0;
   logic [N-1:0] ch_tuple_ready;
   logic [N*CW-1:0] ch_conn_data;
   logic [N-1:0] ch_conn_valid, ch_conn_err;
   logic [TW-1:0] tbl_tuple_data;
   logic tbl_tuple_valid;
   logic [CW-1:0] tbl_conn_data = '0;
   logic tbl_conn_valid = 1'b0;
   logic [31:0] req_cnt, timeout_cnt;
   int n_chk = 0;
   int n_bad = 0;
   int mptr = N - 1;
   logic [31:0] m_req = 0;
   logic [31:0] m_to = 0;
   logic [CW-1:0] m_data [N];
   int g_last;

   nat_conn_arbiter #(.NUM_CH(N), .TUPLE_W(TW), .CONN_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .ch_tuple_data(ch_tuple_data), .ch_tuple_valid(ch_tuple_valid), .ch_tuple_ready(ch_tuple_ready),
      .ch_conn_data(ch_conn_data), .ch_conn_valid(ch_conn_valid), .ch_conn_err(ch_conn_err),
      .tbl_tuple_data(tbl_tuple_data), .tbl_tuple_valid(tbl_tuple_valid),
      .tbl_conn_data(tbl_conn_data), .tbl_conn_valid(tbl_conn_valid),
      .req_cnt(req_cnt), .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 1; k <= N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      return (i < 0) ? '0 : 4'b0001 << i;
   endfunction

   function automatic logic [N*CW-1:0] exp_data();
      logic [N*CW-1:0] v;
      for (int i = 0; i < N; i++) v[i*CW +: CW] = m_data[i];
      return v;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 1;
   endfunction

   // one full transaction from a DUT-idle negedge; lat 1..TO = response that many cycles
   // after the table request, lat 0 = table never answers
   task automatic lookup(input logic [N-1:0] mask, input int lat, input logic [CW-1:0] rd);
      int g, last;
      bit resp;
      logic [TW-1:0] tup;
      for (int i = 0; i < N; i++)
         ch_tuple_data[i*TW +: TW] = {$urandom, $urandom, $urandom, $urandom};
      ch_tuple_valid = mask;
      #1;
      g = rr_pick(mask, mptr);
      g_last = g;
      chk("ready_grant", ch_tuple_ready, onehot(g));
      tup = ch_tuple_data[g*TW +: TW];
      mptr = g;
      m_req = sat_inc(m_req);
      @(negedge clk);
      ch_tuple_valid[g] = 1'b0;
      chk("tbl_valid", tbl_tuple_valid, 1);
      chk("tbl_data", tbl_tuple_data, tup);
      chk("req_cnt", req_cnt, m_req);
      chk("ready_busy", ch_tuple_ready, 0);
      resp = (lat >= 1 && lat <= TO);
      last = (resp ? lat : TO) + 1;
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         tbl_conn_valid = 1'b0;
         if (c < last) chk("no_early", ch_conn_valid, 0);
         if (resp && c == lat) begin
            tbl_conn_data  = rd;
            tbl_conn_valid = 1'b1;
         end
      end
      m_data[g] = resp ? rd : '0;
      if (!resp) m_to = sat_inc(m_to);
      chk("conn_valid", ch_conn_valid, onehot(g));
      chk("conn_err", ch_conn_err, resp ? '0 : onehot(g));
      chk("conn_data", ch_conn_data, exp_data());
      chk("timeout_cnt", timeout_cnt, m_to);
   endtask

   task automatic stray();
      ch_tuple_valid = '0;
      tbl_conn_data  = 16'hBEEF;
      tbl_conn_valid = 1'b1;
      @(negedge clk);
      tbl_conn_valid = 1'b0;
      chk("stray_valid", ch_conn_valid, 0);
      chk("stray_data", ch_conn_data, exp_data());
      @(negedge clk);
      chk("stray_tbl", tbl_tuple_valid, 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_data[i] = '0;
      #1;
      chk("rst_ready", ch_tuple_ready, 0);
      chk("rst_valid", ch_conn_valid, 0);
      chk("rst_tbl", tbl_tuple_valid, 0);
      chk("rst_req", req_cnt, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      // single channel, 3-cycle table latency
      lookup(4'b0001, 3, 16'h1234);
      // all channels requesting: strict rotation
      for (int i = 0; i < 8; i++) begin
         lookup(4'b1111, $urandom_range(1, 5), CW'($urandom));
         chk("rotation", g_last, (i + 1) % N);
      end
      // table silent, then a normal lookup
      lookup(4'b0100, 0, '0);
      lookup(4'b0100, 2, 16'h0042);
      // response exactly on the last wait cycle wins over timeout
      lookup(4'b1000, TO, 16'hA5A5);
      stray();
      for (int i = 0; i < 30; i++)
         lookup(N'($urandom_range(1, 15)), $urandom_range(0, TO), CW'($urandom));
      // reset in the middle of WAIT
      ch_tuple_valid = 4'b0010;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      mptr = N - 1;
      m_req = 0;
      m_to = 0;
      for (int i = 0; i < N; i++) m_data[i] = '0;
      chk("mid_rst_ready", ch_tuple_ready, 0);
      chk("mid_rst_valid", ch_conn_valid, 0);
      chk("mid_rst_err", ch_conn_err, 0);
      chk("mid_rst_tbl", tbl_tuple_valid, 0);
      chk("mid_rst_tdata", tbl_tuple_data, 0);
      chk("mid_rst_cdata", ch_conn_data, 0);
      chk("mid_rst_cnt", {req_cnt, timeout_cnt}, 0);
      @(negedge clk);
      ch_tuple_valid = '0;
      reset = 1'b1;
      for (int i = 0; i < TO + 2; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", ch_conn_valid, 0);
      end
      stray();
      lookup(4'b1111, 1, 16'h0777);
      chk("post_rst_grant", g_last, 0);
      // counter saturation
      force dut.req_cnt = 32'hFFFF_FFFD;
      #1 release dut.req_cnt;
      m_req = 32'hFFFF_FFFD;
      chk("sat_preload", req_cnt, m_req);
      for (int i = 0; i < 4; i++) lookup(4'b1111, 1, CW'($urandom));
      chk("sat_hold", req_cnt, 32'hFFFF_FFFF);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
